// File: rtl/trap_commit_tracker_pkg.sv
// trap_pkg: shared state type, widths, default stall code and PC slot helper for the trap commit tracker
package trap_pkg;
   typedef enum logic [1:0] {RUN, REPORT, HALT} trapState_t;
   localparam int XLEN_CNT = 32;
   localparam int MAX_SLOTS = 8;
   localparam int PC_BUS_W = 32 * MAX_SLOTS;
   localparam logic [31:0] DEFAULT_STALL_CODE = 32'h0000_DEAD;
   function automatic logic [31:0] slot_pc(input logic [PC_BUS_W-1:0] pcVec, input int i);
      return 32'(pcVec >> (32 * i));
   endfunction
endpackage

// File: rtl/trap_commit_tracker_commit_slot_select.sv
// commit_slot_select: locate the oldest trap slot, count the commits that retire with it and find the youngest valid slot
module commit_slot_select #(
   parameter int COMMIT_WIDTH = 2,
   parameter int IDX_W = (COMMIT_WIDTH > 1) ? $clog2(COMMIT_WIDTH) : 1,
   parameter int CNT_W = $clog2(COMMIT_WIDTH + 1)
) (
   input  logic [COMMIT_WIDTH-1:0] valid,
   input  logic [COMMIT_WIDTH-1:0] isTrap,
   output logic                    trapHit,
   output logic [IDX_W-1:0]        trapIdx,
   output logic [CNT_W-1:0]        countedCnt,
   output logic [IDX_W-1:0]        lastIdx
);
   // Scan downward so the lowest trap slot wins, then count valid slots up to it
   always_comb begin
      trapHit = 1'b0;
      trapIdx = '0;
      countedCnt = '0;
      lastIdx = '0;
      for (int i = COMMIT_WIDTH - 1; i >= 0; i--)
         if (valid[i] && isTrap[i]) begin
            trapHit = 1'b1;
            trapIdx = IDX_W'(i);
         end
      for (int i = 0; i < COMMIT_WIDTH; i++) begin
         if (valid[i] && (!trapHit || i <= int'(trapIdx))) countedCnt = countedCnt + CNT_W'(1);
         if (valid[i]) lastIdx = IDX_W'(i);
      end
   end
endmodule

// File: rtl/trap_commit_tracker.sv
// trap_commit_tracker: counts cycles and commits, catches the good trap or a commit stall, strobes the trap monitor once
module trap_commit_tracker
   import trap_pkg::*;
#(
   parameter int          COMMIT_WIDTH = 2,
   parameter int          STALL_LIMIT  = 5000,
   parameter logic [31:0] STALL_CODE   = DEFAULT_STALL_CODE
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [COMMIT_WIDTH-1:0]   commit_valid,
   input  logic [32*COMMIT_WIDTH-1:0] commit_pc,
   input  logic [COMMIT_WIDTH-1:0]   commit_is_trap,
   input  logic [31:0]               trap_code_in,
   output logic                      is_noop_trap,
   output logic [31:0]               trap_code,
   output logic [31:0]               trap_pc,
   output logic [XLEN_CNT-1:0]       cycle_cnt,
   output logic [XLEN_CNT-1:0]       instr_cnt,
   output logic                      halted
);
   localparam int IDX_W = (COMMIT_WIDTH > 1) ? $clog2(COMMIT_WIDTH) : 1;
   localparam int CNT_W = $clog2(COMMIT_WIDTH + 1);
   trapState_t state;
   logic trapHit, anyCommit, stallFire;
   logic [IDX_W-1:0] trapIdx, lastIdx;
   logic [CNT_W-1:0] countedCnt;
   logic [31:0] stallCnt, lastPc;
   logic [PC_BUS_W-1:0] pcWide;
   assign pcWide = PC_BUS_W'(commit_pc);
   assign anyCommit = |commit_valid;
   assign stallFire = (STALL_LIMIT != 0) && !anyCommit && (stallCnt == 32'(STALL_LIMIT - 1));
   commit_slot_select #(.COMMIT_WIDTH(COMMIT_WIDTH), .IDX_W(IDX_W), .CNT_W(CNT_W)) slotSel (
      .valid(commit_valid),
      .isTrap(commit_is_trap),
      .trapHit(trapHit),
      .trapIdx(trapIdx),
      .countedCnt(countedCnt),
      .lastIdx(lastIdx)
   );
   // Run/report/halt sequencing with counters, watchdog and latched trap fields all held in registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= RUN;
         is_noop_trap <= 1'b0;
         halted <= 1'b0;
         trap_code <= '0;
         trap_pc <= '0;
         cycle_cnt <= '0;
         instr_cnt <= '0;
         stallCnt <= '0;
         lastPc <= '0;
      end else begin
         case (state)
            RUN: begin
               cycle_cnt <= cycle_cnt + XLEN_CNT'(1);
               instr_cnt <= instr_cnt + XLEN_CNT'(countedCnt);
               stallCnt <= anyCommit ? '0 : stallCnt + 32'd1;
               if (anyCommit && !trapHit) lastPc <= slot_pc(pcWide, int'(lastIdx));
               if (trapHit || stallFire) begin
                  trap_code <= trapHit ? trap_code_in : STALL_CODE;
                  trap_pc <= trapHit ? slot_pc(pcWide, int'(trapIdx)) : lastPc;
                  is_noop_trap <= 1'b1;
                  halted <= 1'b1;
                  state <= REPORT;
               end
            end
            REPORT: begin
               is_noop_trap <= 1'b0;
               state <= HALT;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_trap_commit_tracker.sv
// tb_trap_commit_tracker: three tracker instances (watchdog 5000, 8, off) checked every cycle against a behavioural model
module tb_trap_commit_tracker;
   localparam int CW = 2;
   bit clk;
   logic reset = 1'b1;
   logic [CW-1:0] commit_valid = '0;
   logic [CW-1:0] commit_is_trap = '0;
   logic [32*CW-1:0] commit_pc = '0;
   logic [31:0] trap_code_in = '0;
   logic strobe [3];
   logic halted [3];
   logic [31:0] code [3];
   logic [31:0] tpc [3];
   logic [31:0] cyc [3];
   logic [31:0] ins [3];
   int checks;
   int errors;
   bit wrapForce;
   int lim [3] = '{5000, 8, 0};
   bit mStrobe [3];
   bit mHalted [3];
   bit [31:0] mCycle [3];
   bit [31:0] mInstr [3];
   bit [31:0] mCode [3];
   bit [31:0] mPc [3];
   bit [31:0] mLast [3];
   int mStall [3];

   always #5 clk = ~clk;

   trap_commit_tracker #(.COMMIT_WIDTH(CW), .STALL_LIMIT(5000)) dut0 (
      .clk(clk), .reset(reset), .commit_valid(commit_valid), .commit_pc(commit_pc),
      .commit_is_trap(commit_is_trap), .trap_code_in(trap_code_in), .is_noop_trap(strobe[0]),
      .trap_code(code[0]), .trap_pc(tpc[0]), .cycle_cnt(cyc[0]), .instr_cnt(ins[0]), .halted(halted[0]));
   trap_commit_tracker #(.COMMIT_WIDTH(CW), .STALL_LIMIT(8)) dut1 (
      .clk(clk), .reset(reset), .commit_valid(commit_valid), .commit_pc(commit_pc),
      .commit_is_trap(commit_is_trap), .trap_code_in(trap_code_in), .is_noop_trap(strobe[1]),
      .trap_code(code[1]), .trap_pc(tpc[1]), .cycle_cnt(cyc[1]), .instr_cnt(ins[1]), .halted(halted[1]));
   trap_commit_tracker #(.COMMIT_WIDTH(CW), .STALL_LIMIT(0)) dut2 (
      .clk(clk), .reset(reset), .commit_valid(commit_valid), .commit_pc(commit_pc),
      .commit_is_trap(commit_is_trap), .trap_code_in(trap_code_in), .is_noop_trap(strobe[2]),
      .trap_code(code[2]), .trap_pc(tpc[2]), .cycle_cnt(cyc[2]), .instr_cnt(ins[2]), .halted(halted[2]));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] pcOf(input int i);
      return 32'(commit_pc >> (32 * i));
   endfunction

   task automatic modelStep(input int k);
      int t;
      int n;
      t = -1;
      n = 0;
      if (reset) begin
         mStrobe[k] = 0; mHalted[k] = 0; mCycle[k] = 0; mInstr[k] = 0;
         mCode[k] = 0; mPc[k] = 0; mLast[k] = 0; mStall[k] = 0;
         return;
      end
      if (mStrobe[k]) begin
         mStrobe[k] = 0;
         return;
      end
      if (mHalted[k]) return;
      for (int i = 0; i < CW; i++)
         if (t < 0 && commit_valid[i] && commit_is_trap[i]) t = i;
      for (int i = 0; i < CW; i++)
         if (commit_valid[i] && (t < 0 || i <= t)) n++;
      mCycle[k] += 1;
      mInstr[k] += 32'(n);
      if (t >= 0) begin
         mCode[k] = trap_code_in;
         mPc[k] = pcOf(t);
         mStrobe[k] = 1;
         mHalted[k] = 1;
      end else if (commit_valid != 0) begin
         mStall[k] = 0;
         for (int i = 0; i < CW; i++)
            if (commit_valid[i]) mLast[k] = pcOf(i);
      end else begin
         mStall[k]++;
         if (lim[k] != 0 && mStall[k] == lim[k]) begin
            mCode[k] = 32'h0000_DEAD;
            mPc[k] = mLast[k];
            mStrobe[k] = 1;
            mHalted[k] = 1;
         end
      end
   endtask

   // Advance the model on each edge and compare every output of every instance just after it
   always @(posedge clk) begin
      for (int k = 0; k < 3; k++) modelStep(k);
      if (wrapForce) mInstr[0] = 32'hFFFF_FFFF;
      #1;
      for (int k = 0; k < 3; k++) begin
         check($sformatf("strobe%0d", k), 32'(strobe[k]), 32'(mStrobe[k]));
         check($sformatf("halted%0d", k), 32'(halted[k]), 32'(mHalted[k]));
         check($sformatf("code%0d", k), code[k], mCode[k]);
         check($sformatf("pc%0d", k), tpc[k], mPc[k]);
         check($sformatf("cycle%0d", k), cyc[k], mCycle[k]);
         check($sformatf("instr%0d", k), ins[k], mInstr[k]);
      end
   end

   task automatic drive(input bit r, input logic [1:0] v, input logic [1:0] t,
                        input logic [31:0] p0, input logic [31:0] p1, input logic [31:0] c);
      @(negedge clk);
      reset = r;
      commit_valid = v;
      commit_is_trap = t;
      commit_pc = {p1, p0};
      trap_code_in = c;
      @(posedge clk);
   endtask

   task automatic doReset(input int n);
      repeat (n) drive(1'b1, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0);
   endtask

   initial begin
      int idlePct;
      logic [1:0] v;
      logic [1:0] tr;
      idlePct = 25;
      doReset(3);
      repeat (10) drive(1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0);
      #2;
      check("idle_cycle", cyc[0], 32'd10);
      check("idle_instr", ins[0], 32'd0);
      check("idle_strobe", 32'(strobe[0]), 32'd0);
      check("idle_halted", 32'(halted[0]), 32'd0);

      doReset(1);
      repeat (4) drive(1'b0, 2'b11, 2'b00, 32'h8000_0000, 32'h8000_0004, 32'h0);
      drive(1'b0, 2'b11, 2'b01, 32'h8000_0040, 32'h8000_0044, 32'h0);
      #2;
      check("trap_instr", ins[0], 32'd9);
      check("trap_cycle", cyc[0], 32'd5);
      check("trap_pc", tpc[0], 32'h8000_0040);
      check("trap_code", code[0], 32'h0);
      check("trap_strobe", 32'(strobe[0]), 32'd1);
      drive(1'b0, 2'b11, 2'b00, 32'h8000_0048, 32'h8000_004C, 32'h0);
      #2;
      check("post_strobe", 32'(strobe[0]), 32'd0);
      check("post_halted", 32'(halted[0]), 32'd1);
      repeat (3) drive(1'b0, 2'b11, 2'b01, 32'h9000_0000, 32'h9000_0004, 32'h77);
      #2;
      check("frozen_instr", ins[0], 32'd9);
      check("frozen_cycle", cyc[0], 32'd5);
      check("frozen_pc", tpc[0], 32'h8000_0040);

      doReset(1);
      drive(1'b0, 2'b11, 2'b11, 32'h8000_0100, 32'h8000_0104, 32'h55);
      #2;
      check("dual_trap_pc", tpc[0], 32'h8000_0100);
      check("dual_trap_instr", ins[0], 32'd1);
      check("dual_trap_code", code[0], 32'h55);
      doReset(1);
      drive(1'b0, 2'b01, 2'b10, 32'h8000_0200, 32'h8000_0204, 32'h66);
      #2;
      check("invalid_trap_strobe", 32'(strobe[0]), 32'd0);
      check("invalid_trap_instr", ins[0], 32'd1);

      doReset(1);
      drive(1'b0, 2'b01, 2'b00, 32'h8000_0010, 32'h8000_0014, 32'h0);
      repeat (7) drive(1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0);
      #2;
      check("wd_early_strobe", 32'(strobe[1]), 32'd0);
      drive(1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0);
      #2;
      check("wd_strobe", 32'(strobe[1]), 32'd1);
      check("wd_code", code[1], 32'h0000_DEAD);
      check("wd_pc", tpc[1], 32'h8000_0010);
      check("wd_cycle", cyc[1], 32'd9);
      doReset(1);
      repeat (8) drive(1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0);
      #2;
      check("wd_cold_strobe", 32'(strobe[1]), 32'd1);
      check("wd_cold_pc", tpc[1], 32'h0);

      doReset(1);
      @(negedge clk);
      reset = 1'b0;
      commit_valid = 2'b00;
      commit_is_trap = 2'b00;
      wrapForce = 1'b1;
      force dut0.instr_cnt = 32'hFFFF_FFFF;
      @(posedge clk);
      #3;
      release dut0.instr_cnt;
      wrapForce = 1'b0;
      drive(1'b0, 2'b11, 2'b00, 32'h8000_0300, 32'h8000_0304, 32'h0);
      #2;
      check("wrap_instr", ins[0], 32'h0000_0001);

      doReset(1);
      repeat (20000) drive(1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0);
      #2;
      check("nowd_halted", 32'(halted[2]), 32'd0);
      check("nowd_cycle", cyc[2], 32'd20000);

      doReset(1);
      drive(1'b0, 2'b01, 2'b01, 32'h8000_0400, 32'h8000_0404, 32'h1);
      drive(1'b1, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0);
      #2;
      check("rst_report_strobe", 32'(strobe[0]), 32'd0);
      check("rst_report_halted", 32'(halted[0]), 32'd0);
      check("rst_report_pc", tpc[0], 32'h0);
      check("rst_report_cycle", cyc[0], 32'd0);
      drive(1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0);
      #2;
      check("rst_resume_cycle", cyc[0], 32'd1);

      for (int c = 0; c < 3000; c++) begin
         if (c % 50 == 0) idlePct = ($urandom_range(0, 1) != 0) ? 90 : 25;
         v = ($urandom_range(0, 99) < idlePct) ? 2'b00 : 2'($urandom_range(1, 3));
         tr = {1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 39) == 0)};
         drive(1'($urandom_range(0, 149) == 0), v, tr, $urandom, $urandom, $urandom);
      end
      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
